// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock period monitor: FSM state encoding and
// default sizing of the counter, lock threshold and synchronizer depth.
package clk_mon_pkg;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_LOCK_CNT    = 4;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2,
      ST_FAULT   = 2'd3
   } state_e;
endpackage

// File: rtl/clk_period_monitor_if.sv
// Control/result bus of the clock period monitor; the controller side is
// the master, the monitor itself is the slave.
interface clk_period_monitor_if
   import clk_mon_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] exp_period;
   logic [7:0]       tol;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             freq_ok;
   logic             locked;
   logic             timeout;
   logic             busy;

   modport master (
      output start, stop, exp_period, tol,
      input  period, period_valid, freq_ok, locked, timeout, busy
   );

   modport slave (
      input  start, stop, exp_period, tol,
      output period, period_valid, freq_ok, locked, timeout, busy
   );
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a one-flop
// rising-edge detector producing a single-cycle pulse in the mclk domain.
module sync_edge_det
   import clk_mon_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic mclk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise_pulse
);
   logic [SYNC_STAGES-1:0] sync_d, sync_q;
   logic                   prev_d, prev_q;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge mclk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/clk_period_monitor.sv
// Measures the period of an asynchronous clock in mclk cycles, checks it
// against an expected value with tolerance, tracks lock and flags timeouts.
module clk_period_monitor
   import clk_mon_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int LOCK_CNT    = DEF_LOCK_CNT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic mclk,
   input  logic rst_n,
   input  logic sig_in,
   clk_period_monitor_if.slave bus
);
   localparam int DIFF_W = CNT_W + 1;
   localparam int CMP_W  = (DIFF_W > 8) ? DIFF_W : 8;
   localparam int LOCK_W = $clog2(LOCK_CNT + 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   // Signed difference one bit wider than the counter so no wrap is possible.
   function automatic logic within_tol(input logic [CNT_W-1:0] meas,
                                       input logic [CNT_W-1:0] expct,
                                       input logic [7:0]       lim);
      logic signed [DIFF_W-1:0] diff;
      logic [DIFF_W-1:0]        mag;
      diff = $signed({1'b0, meas}) - $signed({1'b0, expct});
      mag  = diff[DIFF_W-1] ? DIFF_W'(-diff) : DIFF_W'(diff);
      return CMP_W'(mag) <= CMP_W'(lim);
   endfunction

   logic rise;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .mclk      (mclk),
      .rst_n     (rst_n),
      .async_in  (sig_in),
      .rise_pulse(rise)
   );

   state_e             state_d, state_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   logic [LOCK_W-1:0]  lock_d, lock_q;
   logic [CNT_W-1:0]   exp_d, exp_q;
   logic [7:0]         tol_d, tol_q;
   logic [CNT_W-1:0]   period_d, period_q;
   logic               pvld_d, pvld_q;
   logic               freq_ok_d, freq_ok_q;
   logic               locked_d, locked_q;
   logic               timeout_d, timeout_q;
   logic               busy_d, busy_q;
   logic               meas_ok;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lock_d    = lock_q;
      exp_d     = exp_q;
      tol_d     = tol_q;
      period_d  = period_q;
      pvld_d    = 1'b0;
      freq_ok_d = freq_ok_q;
      timeout_d = timeout_q;
      meas_ok   = within_tol(cnt_q, exp_q, tol_q);

      // stop overrides everything, including a simultaneous start
      if (bus.stop) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         lock_d    = '0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_FAULT: begin
               if (bus.start) begin
                  state_d   = ST_ARM;
                  cnt_d     = '0;
                  exp_d     = bus.exp_period;
                  tol_d     = bus.tol;
                  timeout_d = 1'b0;
               end
            end
            ST_ARM, ST_MEASURE: begin
               if (rise) begin
                  state_d = ST_MEASURE;
                  cnt_d   = CNT_W'(1);
                  if (state_q == ST_MEASURE) begin
                     period_d  = cnt_q;
                     pvld_d    = 1'b1;
                     freq_ok_d = meas_ok;
                     if (!meas_ok)               lock_d = '0;
                     else if (lock_q != LOCK_MAX) lock_d = lock_q + 1'b1;
                  end
               end else if (cnt_q == CNT_MAX) begin
                  state_d   = ST_FAULT;
                  timeout_d = 1'b1;
                  lock_d    = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      locked_d = (lock_d == LOCK_MAX);
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge mclk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         lock_q    <= '0;
         exp_q     <= '0;
         tol_q     <= '0;
         period_q  <= '0;
         pvld_q    <= 1'b0;
         freq_ok_q <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lock_q    <= lock_d;
         exp_q     <= exp_d;
         tol_q     <= tol_d;
         period_q  <= period_d;
         pvld_q    <= pvld_d;
         freq_ok_q <= freq_ok_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.period       = period_q;
   assign bus.period_valid = pvld_q;
   assign bus.freq_ok      = freq_ok_q;
   assign bus.locked       = locked_q;
   assign bus.timeout      = timeout_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_clk_period_monitor.sv
// Bench for clk_period_monitor: directed and randomized sig_in waveforms,
// results compared against a period/tolerance/lock model built from rise times.
module tb_clk_period_monitor;
   localparam int CW = 8;
   localparam int LK = 4;

   logic mclk = 1'b0;
   logic rst_n;
   logic sig_in;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   typedef struct {
      int per;
      bit ok;
      bit lk;
   } obs_t;
   obs_t obs[$];

   clk_period_monitor_if #(.CNT_W(CW)) bus ();

   clk_period_monitor #(.CNT_W(CW), .LOCK_CNT(LK), .SYNC_STAGES(2)) dut (
      .mclk  (mclk),
      .rst_n (rst_n),
      .sig_in(sig_in),
      .bus   (bus)
   );

   always #10 mclk = ~mclk;
   always @(posedge mclk) cyc <= cyc + 1;

   always @(negedge mclk)
      if (bus.period_valid === 1'b1)
         obs.push_back('{int'(bus.period), bus.freq_ok, bus.locked});

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, expv);
      end
   endtask

   // One mclk cycle; single-cycle control pulses drop after the edge.
   task automatic tick();
      @(posedge mclk);
      #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
   endtask

   // Runs one measurement with the given sig_in periods, then compares every
   // reported period against the rise-time differences actually driven.
   task automatic do_run(input int e, input int t, input int plist[$], input bit inj);
      int rises[$];
      int lk, per, hi, d;
      bit ok;
      obs.delete();
      bus.exp_period = CW'(e);
      bus.tol        = 8'(t);
      bus.start      = 1'b1;
      tick();
      chk("busy_after_start", bus.busy, 1);
      repeat (2) tick();
      sig_in = 1'b1;
      rises.push_back(cyc);
      foreach (plist[i]) begin
         hi = plist[i] / 2;
         repeat (hi) tick();
         sig_in = 1'b0;
         if (inj && i == 1) begin
            bus.start      = 1'b1;
            bus.exp_period = CW'(e + 7);
            bus.tol        = 8'(t + 5);
         end
         repeat (plist[i] - hi) tick();
         sig_in = 1'b1;
         rises.push_back(cyc);
      end
      repeat (2) tick();
      sig_in = 1'b0;
      repeat (8) tick();

      chk("n_valid", obs.size(), rises.size() - 1);
      lk = 0;
      per = 0;
      ok = 0;
      for (int i = 1; i < rises.size(); i++) begin
         per = rises[i] - rises[i-1];
         d   = (per > e) ? per - e : e - per;
         ok  = (d <= t);
         lk  = ok ? ((lk < LK) ? lk + 1 : LK) : 0;
         if (i - 1 < obs.size()) begin
            chk($sformatf("period[%0d]", i - 1), obs[i-1].per, per);
            chk($sformatf("freq_ok[%0d]", i - 1), obs[i-1].ok, ok);
            chk($sformatf("locked[%0d]", i - 1), obs[i-1].lk, (lk == LK));
         end
      end

      bus.stop = 1'b1;
      tick();
      chk("stop_busy", bus.busy, 0);
      chk("stop_locked", bus.locked, 0);
      chk("stop_keeps_period", bus.period, per);
      chk("stop_keeps_freq_ok", bus.freq_ok, ok);
      repeat (2) tick();
   endtask

   initial begin
      int plist[$];
      int e, t, np, off, p, k;
      rst_n = 1'b0;
      sig_in = 1'b0;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.exp_period = '0;
      bus.tol = '0;
      repeat (3) tick();
      chk("rst_period", bus.period, 0);
      chk("rst_period_valid", bus.period_valid, 0);
      chk("rst_freq_ok", bus.freq_ok, 0);
      chk("rst_locked", bus.locked, 0);
      chk("rst_timeout", bus.timeout, 0);
      chk("rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // start and stop together while idle: stop wins
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      chk("start_stop_idle_busy", bus.busy, 0);
      repeat (2) tick();

      // N=2, exact match: locks on the 4th measurement
      plist = '{4, 4, 4, 4, 4};
      do_run(4, 0, plist, 1'b0);
      // N=3 against 4+/-1: never in tolerance
      plist = '{6, 6, 6, 6, 6};
      do_run(4, 1, plist, 1'b0);
      // lock, one long period breaks it, then relock
      plist = '{4, 4, 4, 4, 4, 8, 4, 4, 4, 4};
      do_run(4, 0, plist, 1'b0);
      // start during measurement with changed exp/tol must be ignored
      plist = '{4, 4, 4, 4, 4};
      do_run(4, 0, plist, 1'b1);

      for (int r = 0; r < 5; r++) begin
         e  = $urandom_range(4, 20);
         t  = $urandom_range(0, 3);
         np = $urandom_range(5, 9);
         plist.delete();
         for (int i = 0; i < np; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               off = int'($urandom_range(0, 2 * t + 2)) - (t + 1);
               p = e + off;
            end else begin
               p = $urandom_range(2, 24);
            end
            if (p < 2) p = 2;
            plist.push_back(p);
         end
         do_run(e, t, plist, 1'($urandom_range(0, 1)));
      end

      // timeout with sig_in held low
      bus.exp_period = CW'(4);
      bus.tol = 8'd0;
      bus.start = 1'b1;
      tick();
      k = 0;
      while (bus.timeout !== 1'b1 && k < 300) begin
         tick();
         k++;
      end
      chk("timeout_window", (k >= 254 && k <= 258), 1);
      chk("fault_timeout", bus.timeout, 1);
      chk("fault_busy", bus.busy, 1);
      chk("fault_locked", bus.locked, 0);
      bus.start = 1'b1;
      tick();
      chk("fault_restart_timeout", bus.timeout, 0);
      chk("fault_restart_busy", bus.busy, 1);
      bus.stop = 1'b1;
      tick();
      chk("fault_stop_timeout", bus.timeout, 0);
      chk("fault_stop_busy", bus.busy, 0);
      repeat (2) tick();

      // reset in the middle of a measurement
      bus.exp_period = CW'(4);
      bus.tol = 8'd0;
      bus.start = 1'b1;
      tick();
      repeat (2) tick();
      sig_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         repeat (2) tick();
         sig_in = 1'b0;
         repeat (2) tick();
         sig_in = 1'b1;
      end
      tick();
      obs.delete();
      rst_n = 1'b0;
      tick();
      chk("midrst_period", bus.period, 0);
      chk("midrst_period_valid", bus.period_valid, 0);
      chk("midrst_freq_ok", bus.freq_ok, 0);
      chk("midrst_locked", bus.locked, 0);
      chk("midrst_timeout", bus.timeout, 0);
      chk("midrst_busy", bus.busy, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         sig_in = ~sig_in;
      end
      sig_in = 1'b0;
      repeat (4) tick();
      chk("midrst_no_valid", obs.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
